// File: rtl/vi_dac_pkg.sv
// vi_dac_pkg: shared definitions for the dual-channel DAC waveform source.
// Holds the wave_sel encoding, FSM state type, saturation limits, the unity
// gain constant and the 16-bit channel half offset that the V/I RMS monitor
// also uses to unpack the two channels from one beat.
package vi_dac_pkg;

    localparam int DAC_W = 14;

    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_TRI    = 2'd1;
    localparam logic [1:0] WAVE_SQUARE = 2'd2;
    localparam logic [1:0] WAVE_DC     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int SAT_MAX = (1 << (DAC_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DAC_W - 1));

    // Gain of 16384 is unity, so the scaled product is shifted by log2 of it.
    localparam int UNITY_GAIN = 16384;
    localparam int GAIN_SHIFT = $clog2(UNITY_GAIN);

    // CH1 lives at bit 0, CH2 at bit CH_HALF_OFS of each output beat.
    localparam int CH_HALF_OFS = 16;

endpackage

// File: rtl/vi_dac_chan.sv
// vi_dac_chan: one channel of the waveform pipeline.
//   stage 1 (on ce): shape from phase, capture amp/calib alongside it
//   stage 2 (on ce): scale by amp, add calib, saturate to DAC_WIDTH bits
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   ce             pipeline advance
//   phase_msb      top DAC_WIDTH+1 bits of this channel's phase
//   wave_sel       waveform select
//   amp            unsigned gain, UNITY_GAIN is unity
//   calib          signed offset added after scaling
//   sample         saturated signed sample (stage 2 register)
module vi_dac_chan
    import vi_dac_pkg::*;
#(
    parameter int DAC_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [DAC_WIDTH:0]    phase_msb,
    input  logic [1:0]            wave_sel,
    input  logic [14:0]           amp,
    input  logic signed [15:0]    calib,
    output logic [DAC_WIDTH-1:0]  sample
);

    localparam int PROD_W = DAC_WIDTH + 16;
    localparam logic [DAC_WIDTH-1:0] W_MAX = {1'b0, {(DAC_WIDTH-1){1'b1}}};
    localparam logic [DAC_WIDTH-1:0] W_MIN = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] SUM_MAX = PROD_W'(SAT_MAX);
    localparam logic signed [PROD_W-1:0] SUM_MIN = PROD_W'(SAT_MIN);

    logic [DAC_WIDTH-1:0] q, r, t, shape_next;
    logic [DAC_WIDTH-1:0] shape_reg;
    logic [14:0]          amp_reg;
    logic signed [15:0]   calib_reg;
    logic [DAC_WIDTH-1:0] sample_reg, sample_next;

    logic signed [PROD_W-1:0] w_ext, amp_ext, product, scaled, sum;

    // q is phase[top:top-13], r is one bit lower; the triangle folds r about
    // the half period so it ramps up then back down.
    always_comb begin
        q = phase_msb[DAC_WIDTH:1];
        r = phase_msb[DAC_WIDTH-1:0];
        t = phase_msb[DAC_WIDTH] ? ~r : r;
        case (wave_sel)
            WAVE_SAW:    shape_next = {~q[DAC_WIDTH-1], q[DAC_WIDTH-2:0]};
            WAVE_TRI:    shape_next = {~t[DAC_WIDTH-1], t[DAC_WIDTH-2:0]};
            WAVE_SQUARE: shape_next = phase_msb[DAC_WIDTH] ? W_MIN : W_MAX;
            default:     shape_next = W_MAX;
        endcase
    end

    // Full-width signed product; arithmetic shift floors toward -inf.
    always_comb begin
        w_ext   = PROD_W'($signed(shape_reg));
        amp_ext = $signed(PROD_W'({1'b0, amp_reg}));
        product = w_ext * amp_ext;
        scaled  = product >>> GAIN_SHIFT;
        sum     = scaled + PROD_W'(calib_reg);
        if (sum > SUM_MAX) begin
            sample_next = W_MAX;
        end else if (sum < SUM_MIN) begin
            sample_next = W_MIN;
        end else begin
            sample_next = sum[DAC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shape_reg  <= '0;
            amp_reg    <= '0;
            calib_reg  <= '0;
            sample_reg <= '0;
        end else if (ce) begin
            shape_reg  <= shape_next;
            amp_reg    <= amp;
            calib_reg  <= calib;
            sample_reg <= sample_next;
        end
    end

    assign sample = sample_reg;

endmodule

// File: rtl/vi_dac_stream.sv
// vi_dac_stream: dual-channel waveform source with AXI-Stream output.
// Phase accumulator + burst FSM issue samples into two vi_dac_chan
// pipelines; results are packed CH1 low / CH2 high into a 32-bit beat held
// in the output register until accepted.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   enable                     level: start/continue (1), stop request (0)
//   wave_sel                   0 saw, 1 triangle, 2 square, 3 DC
//   phase_inc, phase_ofs_CH2   phase step, CH2 phase offset
//   n_periods                  burst length in CH1 periods, 0 = continuous
//   amp_CHx, calib_CHx         per-channel gain and offset
//   M_AXIS_tdata/tvalid/tready AXI-Stream master
//   busy, period_count, done   status
module vi_dac_stream
    import vi_dac_pkg::*;
#(
    parameter int DAC_WIDTH        = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int COUNT_WIDTH      = 32,
    parameter int PHASE_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [1:0]                  wave_sel,
    input  logic [PHASE_WIDTH-1:0]      phase_inc,
    input  logic [PHASE_WIDTH-1:0]      phase_ofs_CH2,
    input  logic [COUNT_WIDTH-1:0]      n_periods,
    input  logic [14:0]                 amp_CH1,
    input  logic [14:0]                 amp_CH2,
    input  logic signed [15:0]          calib_CH1,
    input  logic signed [15:0]          calib_CH2,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic                        busy,
    output logic [COUNT_WIDTH-1:0]      period_count,
    output logic                        done
);

    localparam int NCH = 2;

    state_t                      state_reg;
    logic [PHASE_WIDTH-1:0]      phase_reg;
    logic [COUNT_WIDTH-1:0]      period_count_reg;
    logic                        v1_reg, v2_reg, tvalid_reg;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_reg;
    logic                        busy_reg, done_reg, burst_end_reg;

    logic                        ce, issue, carry, last_period;
    logic [PHASE_WIDTH:0]        phase_sum;
    logic [COUNT_WIDTH-1:0]      pc_plus;

    logic [PHASE_WIDTH-1:0]      ch_phase  [NCH];
    logic [14:0]                 ch_amp    [NCH];
    logic signed [15:0]          ch_calib  [NCH];
    logic [DAC_WIDTH-1:0]        ch_sample [NCH];
    logic [AXIS_TDATA_WIDTH-1:0] beat_packed;
    logic                        unused_phase_lsb;

    // Whole pipeline moves only when the output register can take a beat.
    assign ce    = ~tvalid_reg | M_AXIS_tready;
    assign issue = (state_reg == ST_RUN) && enable && ce;

    assign phase_sum   = {1'b0, phase_reg} + {1'b0, phase_inc};
    assign carry       = phase_sum[PHASE_WIDTH];
    assign pc_plus     = period_count_reg + COUNT_WIDTH'(1);
    assign last_period = carry && (n_periods != '0) && (pc_plus == n_periods);

    assign ch_phase[0] = phase_reg;
    assign ch_phase[1] = phase_reg + phase_ofs_CH2;
    assign ch_amp[0]   = amp_CH1;
    assign ch_amp[1]   = amp_CH2;
    assign ch_calib[0] = calib_CH1;
    assign ch_calib[1] = calib_CH2;

    // Only the top DAC_WIDTH+1 phase bits shape the waveform.
    assign unused_phase_lsb = ^{ch_phase[0][PHASE_WIDTH-DAC_WIDTH-2:0],
                                ch_phase[1][PHASE_WIDTH-DAC_WIDTH-2:0]};

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            vi_dac_chan #(
                .DAC_WIDTH (DAC_WIDTH)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .ce        (ce),
                .phase_msb (ch_phase[gi][PHASE_WIDTH-1 -: DAC_WIDTH+1]),
                .wave_sel  (wave_sel),
                .amp       (ch_amp[gi]),
                .calib     (ch_calib[gi]),
                .sample    (ch_sample[gi])
            );
            // Each half carries the sample sign-extended to 16 bits.
            assign beat_packed[gi*CH_HALF_OFS +: CH_HALF_OFS] =
                {{(CH_HALF_OFS-DAC_WIDTH){ch_sample[gi][DAC_WIDTH-1]}}, ch_sample[gi]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            phase_reg        <= '0;
            period_count_reg <= '0;
            v1_reg           <= 1'b0;
            v2_reg           <= 1'b0;
            tvalid_reg       <= 1'b0;
            tdata_reg        <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            burst_end_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (ce) begin
                v1_reg     <= issue;
                v2_reg     <= v1_reg;
                tvalid_reg <= v2_reg;
                if (v2_reg) begin
                    tdata_reg <= beat_packed;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        phase_reg        <= '0;
                        period_count_reg <= '0;
                        burst_end_reg    <= 1'b0;
                        busy_reg         <= 1'b1;
                        state_reg        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_reg <= ST_DRAIN;
                    end else if (ce) begin
                        phase_reg <= phase_sum[PHASE_WIDTH-1:0];
                        if (carry) begin
                            period_count_reg <= pc_plus;
                        end
                        if (last_period) begin
                            burst_end_reg <= 1'b1;
                            state_reg     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // With ce high and no stage valid, this edge empties the
                    // output register (final handshake or already empty).
                    if (ce && !v1_reg && !v2_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= burst_end_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign M_AXIS_tdata  = tdata_reg;
    assign M_AXIS_tvalid = tvalid_reg;
    assign busy          = busy_reg;
    assign period_count  = period_count_reg;
    assign done          = done_reg;

endmodule
